// File: rtl/cpu_defs.sv
// Shared definitions for the 8-bit CPU control path: opcodes, bus sources,
// sequencer state encoding and the grouped load/strobe record.
package cpu_defs;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_PC   = 3'd1;
    localparam logic [2:0] BUS_MEM  = 3'd2;
    localparam logic [2:0] BUS_IRL  = 3'd3;
    localparam logic [2:0] BUS_A    = 3'd4;
    localparam logic [2:0] BUS_ALU  = 3'd5;

    typedef enum logic [2:0] {
        ST_FETCH0 = 3'd0,
        ST_FETCH1 = 3'd1,
        ST_EX1    = 3'd2,
        ST_EX2    = 3'd3,
        ST_EX3    = 3'd4,
        ST_HALT   = 3'd5
    } seq_state_t;

    typedef struct packed {
        logic l_mar;
        logic l_ir;
        logic l_a;
        logic l_b;
        logic l_out;
        logic l_flags;
        logic pc_inc;
        logic pc_load;
        logic mem_rd;
        logic mem_wr;
    } strobe_t;

endpackage

// File: rtl/cpu_ctrl_seq_if.sv
// Control interface between the sequencer (master) and the datapath (slave):
// IR/flag feedback in, bus select and register/memory strobes out.
interface cpu_ctrl_seq_if #(
    parameter int OPW  = 4,
    parameter int SELW = 3
);
    logic            run;
    logic [OPW-1:0]  opcode;
    logic            carry_f;
    logic            zero_f;
    logic [SELW-1:0] bus_sel;
    logic            l_mar;
    logic            l_ir;
    logic            l_a;
    logic            l_b;
    logic            l_out;
    logic            l_flags;
    logic            pc_inc;
    logic            pc_load;
    logic            mem_rd;
    logic            mem_wr;
    logic            alu_sub;
    logic            halted;

    modport master (
        input  run, opcode, carry_f, zero_f,
        output bus_sel, l_mar, l_ir, l_a, l_b, l_out, l_flags,
               pc_inc, pc_load, mem_rd, mem_wr, alu_sub, halted
    );

    modport slave (
        output run, opcode, carry_f, zero_f,
        input  bus_sel, l_mar, l_ir, l_a, l_b, l_out, l_flags,
               pc_inc, pc_load, mem_rd, mem_wr, alu_sub, halted
    );
endinterface

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle fetch/execute sequencer: one state register plus a combinational
// decode of state, opcode and flags into bus select and load strobes.
module cpu_ctrl_seq
    import cpu_defs::*;
#(
    parameter int OPW  = 4,
    parameter int SELW = 3
) (
    input  logic           clk,
    input  logic           rst,
    cpu_ctrl_seq_if.master cif
);

    seq_state_t      state_reg;
    seq_state_t      state_next;
    strobe_t         strobe_dec;
    logic [SELW-1:0] bus_dec;
    logic            sub_dec;
    logic [OPW-1:0]  op;

    assign op = cif.opcode;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_FETCH0;
        end else if (cif.run) begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        strobe_dec = '0;
        bus_dec    = SELW'(BUS_NONE);
        sub_dec    = 1'b0;
        case (state_reg)
            ST_FETCH0: begin
                bus_dec          = SELW'(BUS_PC);
                strobe_dec.l_mar = 1'b1;
                state_next       = ST_FETCH1;
            end
            ST_FETCH1: begin
                bus_dec           = SELW'(BUS_MEM);
                strobe_dec.mem_rd = 1'b1;
                strobe_dec.l_ir   = 1'b1;
                strobe_dec.pc_inc = 1'b1;
                state_next        = ST_EX1;
            end
            ST_EX1: begin
                state_next = ST_FETCH0;
                case (op)
                    OPW'(OP_LDA), OPW'(OP_ADD), OPW'(OP_SUB), OPW'(OP_STA): begin
                        bus_dec          = SELW'(BUS_IRL);
                        strobe_dec.l_mar = 1'b1;
                        state_next       = ST_EX2;
                    end
                    OPW'(OP_LDI): begin
                        bus_dec        = SELW'(BUS_IRL);
                        strobe_dec.l_a = 1'b1;
                    end
                    OPW'(OP_JMP): begin
                        bus_dec            = SELW'(BUS_IRL);
                        strobe_dec.pc_load = 1'b1;
                    end
                    OPW'(OP_JC): begin
                        bus_dec            = SELW'(BUS_IRL);
                        strobe_dec.pc_load = cif.carry_f;
                    end
                    OPW'(OP_JZ): begin
                        bus_dec            = SELW'(BUS_IRL);
                        strobe_dec.pc_load = cif.zero_f;
                    end
                    OPW'(OP_OUT): begin
                        bus_dec          = SELW'(BUS_A);
                        strobe_dec.l_out = 1'b1;
                    end
                    OPW'(OP_HLT): state_next = ST_HALT;
                    // NOP and the unassigned opcodes fall through as a single idle step
                    default: ;
                endcase
            end
            ST_EX2: begin
                state_next = ST_FETCH0;
                case (op)
                    OPW'(OP_LDA): begin
                        bus_dec           = SELW'(BUS_MEM);
                        strobe_dec.mem_rd = 1'b1;
                        strobe_dec.l_a    = 1'b1;
                    end
                    OPW'(OP_ADD), OPW'(OP_SUB): begin
                        bus_dec           = SELW'(BUS_MEM);
                        strobe_dec.mem_rd = 1'b1;
                        strobe_dec.l_b    = 1'b1;
                        state_next        = ST_EX3;
                    end
                    OPW'(OP_STA): begin
                        bus_dec           = SELW'(BUS_A);
                        strobe_dec.mem_wr = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_EX3: begin
                bus_dec            = SELW'(BUS_ALU);
                strobe_dec.l_a     = 1'b1;
                strobe_dec.l_flags = 1'b1;
                sub_dec            = (op == OPW'(OP_SUB));
                state_next         = ST_FETCH0;
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_FETCH0;
        endcase
    end

    // Reset silences everything; a frozen sequencer keeps its bus/ALU decode
    // visible but must not load any register or touch memory.
    always_comb begin
        cif.bus_sel = SELW'(BUS_NONE);
        cif.alu_sub = 1'b0;
        cif.halted  = 1'b0;
        cif.l_mar   = 1'b0;
        cif.l_ir    = 1'b0;
        cif.l_a     = 1'b0;
        cif.l_b     = 1'b0;
        cif.l_out   = 1'b0;
        cif.l_flags = 1'b0;
        cif.pc_inc  = 1'b0;
        cif.pc_load = 1'b0;
        cif.mem_rd  = 1'b0;
        cif.mem_wr  = 1'b0;
        if (!rst) begin
            cif.bus_sel = bus_dec;
            cif.alu_sub = sub_dec;
            cif.halted  = (state_reg == ST_HALT);
            if (cif.run) begin
                cif.l_mar   = strobe_dec.l_mar;
                cif.l_ir    = strobe_dec.l_ir;
                cif.l_a     = strobe_dec.l_a;
                cif.l_b     = strobe_dec.l_b;
                cif.l_out   = strobe_dec.l_out;
                cif.l_flags = strobe_dec.l_flags;
                cif.pc_inc  = strobe_dec.pc_inc;
                cif.pc_load = strobe_dec.pc_load;
                cif.mem_rd  = strobe_dec.mem_rd;
                cif.mem_wr  = strobe_dec.mem_wr;
            end
        end
    end

endmodule
